// File: rtl/branch_predictor_if.sv
// Fetch/resolve bundle between the pipeline and the branch predictor.
// The predictor side takes the slave modport; the pipeline (or a bench) takes master.
interface branch_predictor_if;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;

  logic        upd_valid;
  logic        upd_is_branch;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;

  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  modport slave (
    input  if_valid, if_pc,
    output pred_hit, pred_taken, pred_target,
    input  upd_valid, upd_is_branch, upd_pc, upd_taken, upd_target,
    input  upd_pred_taken, upd_pred_target,
    output mispredict, redirect_pc, stat_branches, stat_mispredicts
  );

  modport master (
    output if_valid, if_pc,
    input  pred_hit, pred_taken, pred_target,
    output upd_valid, upd_is_branch, upd_pc, upd_taken, upd_target,
    output upd_pred_taken, upd_pred_target,
    input  mispredict, redirect_pc, stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BHT+BTB: combinational lookup at IF, training and registered
// mispredict/redirect from resolved branches at ID, with saturating statistics.
module branch_predictor #(
  parameter int IDX_W = 6,
  parameter int TAG_W = 8
) (
  input  logic            clk,
  input  logic            resetn,
  branch_predictor_if.slave bus
);
  localparam int ENTRIES = 1 << IDX_W;

  // Per-entry state lives in the generate blocks; these are read-side views.
  logic [ENTRIES-1:0] valid_vec;
  logic [TAG_W-1:0]   tag_vec    [ENTRIES];
  logic [31:0]        target_vec [ENTRIES];
  logic [1:0]         ctr_vec    [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;

  assign lk_idx = bus.if_pc[IDX_W+1:2];
  assign lk_tag = bus.if_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign up_idx = bus.upd_pc[IDX_W+1:2];
  assign up_tag = bus.upd_pc[IDX_W+TAG_W+1:IDX_W+2];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.if_pc[31:IDX_W+TAG_W+2], bus.if_pc[1:0],
                            bus.upd_pc[31:IDX_W+TAG_W+2], bus.upd_pc[1:0]};

  // Lookup always sees the table as it stood before this cycle's update edge.
  logic lk_hit;
  assign lk_hit          = bus.if_valid & valid_vec[lk_idx] & (tag_vec[lk_idx] == lk_tag);
  assign bus.pred_hit    = lk_hit;
  assign bus.pred_taken  = lk_hit & ctr_vec[lk_idx][1];
  assign bus.pred_target = bus.pred_taken ? target_vec[lk_idx] : bus.if_pc + 32'd4;

  logic upd_en;
  logic up_hit;
  logic [1:0] ctr_next;

  assign upd_en = bus.upd_valid & bus.upd_is_branch;
  assign up_hit = valid_vec[up_idx] & (tag_vec[up_idx] == up_tag);

  always_comb begin
    ctr_next = ctr_vec[up_idx];
    if (bus.upd_taken) begin
      if (ctr_vec[up_idx] != 2'b11) ctr_next = ctr_vec[up_idx] + 2'b01;
    end else begin
      if (ctr_vec[up_idx] != 2'b00) ctr_next = ctr_vec[up_idx] - 2'b01;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic             valid_reg;
      logic [TAG_W-1:0] tag_reg;
      logic [31:0]      target_reg;
      logic [1:0]       ctr_reg;
      logic             sel;

      assign sel = upd_en & (up_idx == IDX_W'(gi));

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          valid_reg  <= 1'b0;
          tag_reg    <= '0;
          target_reg <= '0;
          ctr_reg    <= 2'b00;
        end else if (sel) begin
          if (up_hit) begin
            ctr_reg <= ctr_next;
            if (bus.upd_taken) target_reg <= bus.upd_target;
          end else if (bus.upd_taken) begin
            // Taken miss replaces whatever lives at this index.
            valid_reg  <= 1'b1;
            tag_reg    <= up_tag;
            target_reg <= bus.upd_target;
            ctr_reg    <= 2'b10;
          end
        end
      end

      assign valid_vec[gi]  = valid_reg;
      assign tag_vec[gi]    = tag_reg;
      assign target_vec[gi] = target_reg;
      assign ctr_vec[gi]    = ctr_reg;
    end
  endgenerate

  logic        mis_cond;
  logic [31:0] redirect_next;
  logic        mispredict_reg;
  logic [31:0] redirect_reg;
  logic [31:0] stat_branches_reg;
  logic [31:0] stat_mispredicts_reg;

  assign mis_cond = upd_en & ((bus.upd_taken != bus.upd_pred_taken) |
                              (bus.upd_taken & (bus.upd_target != bus.upd_pred_target)));
  // Not-taken fall-through resumes after the delay slot.
  assign redirect_next = bus.upd_taken ? bus.upd_target : bus.upd_pc + 32'd8;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mispredict_reg       <= 1'b0;
      redirect_reg         <= '0;
      stat_branches_reg    <= '0;
      stat_mispredicts_reg <= '0;
    end else begin
      mispredict_reg <= mis_cond;
      if (mis_cond) redirect_reg <= redirect_next;
      if (upd_en && (stat_branches_reg != 32'hFFFF_FFFF))
        stat_branches_reg <= stat_branches_reg + 32'd1;
      if (mis_cond && (stat_mispredicts_reg != 32'hFFFF_FFFF))
        stat_mispredicts_reg <= stat_mispredicts_reg + 32'd1;
    end
  end

  assign bus.mispredict       = mispredict_reg;
  assign bus.redirect_pc      = redirect_reg;
  assign bus.stat_branches    = stat_branches_reg;
  assign bus.stat_mispredicts = stat_mispredicts_reg;
endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: vector table for lookup/training, scoreboard for
// the registered mispredict/stat outputs, plus reset and saturation sequences.
module tb_branch_predictor;
  logic clk;
  logic resetn;

  branch_predictor_if bus();

  branch_predictor #(.IDX_W(6), .TAG_W(8)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        lv;
    logic [31:0] lpc;
    logic        eh;
    logic        et;
    logic [31:0] etgt;
    logic        uv;
    logic        ub;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        upt;
    logic [31:0] uptgt;
    logic        emis;
    logic [31:0] ered;
  } vec_t;

  typedef struct {
    logic        mis;
    logic [31:0] red;
    logic [31:0] br;
    logic [31:0] mp;
  } exp_t;

  localparam logic [31:0] PA = 32'h0040_0010;
  localparam logic [31:0] PB = 32'h0040_0110;
  localparam logic [31:0] PC = 32'h0040_0020;
  localparam logic [31:0] PW = 32'hFFFF_FFFC;
  localparam int NV = 18;

  vec_t vecs [NV];
  exp_t sb [$];
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] m_br, m_mp, m_red;

  function automatic vec_t mk(
    input logic lv, input logic [31:0] lpc, input logic eh, input logic et, input logic [31:0] etgt,
    input logic uv, input logic ub, input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
    input logic upt, input logic [31:0] uptgt, input logic emis, input logic [31:0] ered);
    vec_t v;
    v.lv = lv; v.lpc = lpc; v.eh = eh; v.et = et; v.etgt = etgt;
    v.uv = uv; v.ub = ub; v.upc = upc; v.ut = ut; v.utgt = utgt;
    v.upt = upt; v.uptgt = uptgt; v.emis = emis; v.ered = ered;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic sb_check();
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("mispredict", {31'd0, bus.mispredict}, {31'd0, e.mis});
      chk("redirect_pc", bus.redirect_pc, e.red);
      chk("stat_branches", bus.stat_branches, e.br);
      chk("stat_mispredicts", bus.stat_mispredicts, e.mp);
    end
  endtask

  task automatic drive_upd(input logic uv, input logic ub, input logic [31:0] upc, input logic ut,
                           input logic [31:0] utgt, input logic upt, input logic [31:0] uptgt);
    bus.upd_valid = uv; bus.upd_is_branch = ub; bus.upd_pc = upc; bus.upd_taken = ut;
    bus.upd_target = utgt; bus.upd_pred_taken = upt; bus.upd_pred_target = uptgt;
  endtask

  initial begin
    vecs[0]  = mk(1, PA, 0, 0, 32'h0040_0014, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, PA, 0, 0, 32'h0040_0014, 1, 1, PA, 1, 32'h0040_0100, 0, 32'h0040_0014, 1, 32'h0040_0100);
    vecs[2]  = mk(1, PA, 1, 1, 32'h0040_0100, 1, 1, PA, 1, 32'h0040_0100, 1, 32'h0040_0100, 0, 0);
    vecs[3]  = vecs[2];
    vecs[4]  = vecs[2];
    vecs[5]  = mk(1, PA, 1, 1, 32'h0040_0100, 1, 1, PA, 0, 32'h0040_0100, 1, 32'h0040_0100, 1, 32'h0040_0018);
    vecs[6]  = vecs[5];
    vecs[7]  = mk(1, PA, 1, 0, 32'h0040_0014, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    vecs[8]  = mk(1, PA, 1, 0, 32'h0040_0014, 1, 1, PA, 1, 32'h0040_0200, 1, 32'h0040_0100, 1, 32'h0040_0200);
    vecs[9]  = mk(1, PA, 1, 1, 32'h0040_0200, 1, 0, PC, 1, 32'h0040_0700, 0, 0, 0, 0);
    vecs[10] = mk(1, PA, 1, 1, 32'h0040_0200, 1, 1, PB, 1, 32'h0040_0300, 0, 32'h0040_0114, 1, 32'h0040_0300);
    vecs[11] = mk(1, PA, 0, 0, 32'h0040_0014, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    vecs[12] = mk(1, PB, 1, 1, 32'h0040_0300, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    vecs[13] = mk(1, PC, 0, 0, 32'h0040_0024, 1, 1, PC, 0, 32'h0040_0700, 0, 32'h0040_0024, 0, 0);
    vecs[14] = mk(1, PC, 0, 0, 32'h0040_0024, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    vecs[15] = mk(0, PB, 0, 0, 32'h0040_0114, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    vecs[16] = mk(1, PW, 0, 0, 32'h0000_0000, 1, 1, PW, 0, 0, 1, 32'h0000_0000, 1, 32'h0000_0004);
    vecs[17] = mk(1, PW, 0, 0, 32'h0000_0000, 0, 0, 0,  0, 0, 0, 0, 0, 0);

    resetn = 1'b0;
    bus.if_valid = 1'b0;
    bus.if_pc = 32'h0;
    drive_upd(0, 0, 0, 0, 0, 0, 0);
    m_br = 0; m_mp = 0; m_red = 0;

    #3;
    chk("rst_mispredict", {31'd0, bus.mispredict}, 32'd0);
    chk("rst_redirect", bus.redirect_pc, 32'd0);
    chk("rst_stat_branches", bus.stat_branches, 32'd0);
    chk("rst_stat_mispredicts", bus.stat_mispredicts, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      exp_t e;
      @(negedge clk);
      sb_check();
      bus.if_valid = vecs[i].lv;
      bus.if_pc    = vecs[i].lpc;
      drive_upd(vecs[i].uv, vecs[i].ub, vecs[i].upc, vecs[i].ut, vecs[i].utgt,
                vecs[i].upt, vecs[i].uptgt);
      #1;
      $display("vec %0d: pc=%h hit=%b taken=%b tgt=%h | upd v=%b br=%b pc=%h t=%b",
               i, bus.if_pc, bus.pred_hit, bus.pred_taken, bus.pred_target,
               bus.upd_valid, bus.upd_is_branch, bus.upd_pc, bus.upd_taken);
      chk($sformatf("v%0d_hit", i), {31'd0, bus.pred_hit}, {31'd0, vecs[i].eh});
      chk($sformatf("v%0d_taken", i), {31'd0, bus.pred_taken}, {31'd0, vecs[i].et});
      chk($sformatf("v%0d_target", i), bus.pred_target, vecs[i].etgt);
      if (vecs[i].uv && vecs[i].ub) m_br = m_br + 1;
      if (vecs[i].emis) begin
        m_mp  = m_mp + 1;
        m_red = vecs[i].ered;
      end
      e.mis = vecs[i].emis; e.red = m_red; e.br = m_br; e.mp = m_mp;
      sb.push_back(e);
    end

    // Mid-cycle reset during an update burst.
    @(negedge clk);
    sb_check();
    bus.if_valid = 1'b0;
    drive_upd(1, 1, PA, 1, 32'h0040_0500, 0, 32'h0040_0014);
    @(negedge clk);
    $display("seq reset: pre-reset mispredict=%b redirect=%h", bus.mispredict, bus.redirect_pc);
    chk("pre_rst_mispredict", {31'd0, bus.mispredict}, 32'd1);
    chk("pre_rst_redirect", bus.redirect_pc, 32'h0040_0500);
    chk("pre_rst_stat_branches", bus.stat_branches, m_br + 1);
    drive_upd(1, 1, PC, 1, 32'h0040_0600, 0, 32'h0040_0024);
    bus.if_valid = 1'b1;
    bus.if_pc = PA;
    #2 resetn = 1'b0;
    #1;
    $display("seq reset: in-reset mispredict=%b redirect=%h hit=%b", bus.mispredict, bus.redirect_pc, bus.pred_hit);
    chk("async_rst_mispredict", {31'd0, bus.mispredict}, 32'd0);
    chk("async_rst_redirect", bus.redirect_pc, 32'd0);
    chk("async_rst_stat_branches", bus.stat_branches, 32'd0);
    chk("async_rst_stat_mispredicts", bus.stat_mispredicts, 32'd0);
    chk("async_rst_hit", {31'd0, bus.pred_hit}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    bus.if_pc = PC;
    #1;
    chk("discarded_upd_hit", {31'd0, bus.pred_hit}, 32'd0);
    @(negedge clk);
    $display("seq reset: first edge mispredict=%b redirect=%h br=%0d", bus.mispredict, bus.redirect_pc, bus.stat_branches);
    chk("post_rst_mispredict", {31'd0, bus.mispredict}, 32'd1);
    chk("post_rst_redirect", bus.redirect_pc, 32'h0040_0600);
    chk("post_rst_stat_branches", bus.stat_branches, 32'd1);
    chk("post_rst_stat_mispredicts", bus.stat_mispredicts, 32'd1);
    drive_upd(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("post_rst_hit", {31'd0, bus.pred_hit}, 32'd1);
    chk("post_rst_taken", {31'd0, bus.pred_taken}, 32'd1);
    chk("post_rst_target", bus.pred_target, 32'h0040_0600);

    // Statistics saturation.
    @(negedge clk);
    force dut.stat_branches_reg = 32'hFFFF_FFFF;
    force dut.stat_mispredicts_reg = 32'hFFFF_FFFF;
    #1;
    release dut.stat_branches_reg;
    release dut.stat_mispredicts_reg;
    #1;
    chk("sat_preload", bus.stat_branches, 32'hFFFF_FFFF);
    drive_upd(1, 1, PC, 0, 32'h0040_0600, 1, 32'h0040_0600);
    @(negedge clk);
    $display("seq sat: mispredict=%b redirect=%h br=%h mp=%h", bus.mispredict, bus.redirect_pc, bus.stat_branches, bus.stat_mispredicts);
    chk("sat_mispredict", {31'd0, bus.mispredict}, 32'd1);
    chk("sat_redirect", bus.redirect_pc, 32'h0040_0028);
    chk("sat_stat_branches", bus.stat_branches, 32'hFFFF_FFFF);
    chk("sat_stat_mispredicts", bus.stat_mispredicts, 32'hFFFF_FFFF);
    drive_upd(1, 1, PC, 0, 32'h0040_0600, 0, 32'h0040_0024);
    @(negedge clk);
    $display("seq sat: mispredict=%b redirect=%h br=%h", bus.mispredict, bus.redirect_pc, bus.stat_branches);
    chk("sat2_mispredict", {31'd0, bus.mispredict}, 32'd0);
    chk("sat2_redirect_hold", bus.redirect_pc, 32'h0040_0028);
    chk("sat2_stat_branches", bus.stat_branches, 32'hFFFF_FFFF);
    drive_upd(0, 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
